// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and interrupt-entry controller for a short in-order pipeline.
//   - Operand forwarding select for the two decode-stage sources
//     (priority EX > MEM > WB; WB is optional through FWD_WB).
//   - Load-use stall, and taken-branch flush that overrides the stall.
//   - Interrupt entry sequencer IDLE -> DRAIN -> PUSH -> VECTOR -> ISR,
//     which leaves ISR when an RTI retires from decode.
//
// Ports
//   clk, reset                  clock; synchronous active-high reset
//   intr_req                    level interrupt request
//   id_valid/use_a/use_b/is_rti decode-stage qualifiers
//   id_rs_a, id_rs_b            decode source register addresses
//   ex_valid/reg_write/mem_read/branch_taken   execute-stage status
//   ex_rd, mem_rd, wb_rd        destination register per stage
//   mem_reg_write, wb_reg_write write enables per stage
//   stall_f, stall_d            hold fetch / decode registers
//   flush_d, flush_ex, flush_m  bubble the decode / execute / memory slot
//   fwd_a_sel, fwd_b_sel        0=regfile 1=EX 2=MEM 3=WB
//   intr_ack, pc_push, flag_save, vec_load, flag_restore  one-cycle pulses
//   intr_active                 high from vector load until RTI retires
//   state_dbg                   current interrupt FSM state (debug)
module pipe_hazard_ctrl #(
  parameter int RAW    = 2,
  parameter int DRAIN  = 3,
  parameter int FWD_WB = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           intr_req,
  input  logic           id_valid,
  input  logic           id_use_a,
  input  logic           id_use_b,
  input  logic           id_is_rti,
  input  logic [RAW-1:0] id_rs_a,
  input  logic [RAW-1:0] id_rs_b,
  input  logic           ex_valid,
  input  logic           ex_reg_write,
  input  logic           ex_mem_read,
  input  logic           ex_branch_taken,
  input  logic [RAW-1:0] ex_rd,
  input  logic [RAW-1:0] mem_rd,
  input  logic [RAW-1:0] wb_rd,
  input  logic           mem_reg_write,
  input  logic           wb_reg_write,
  output logic           stall_f,
  output logic           stall_d,
  output logic           flush_d,
  output logic           flush_ex,
  output logic           flush_m,
  output logic [1:0]     fwd_a_sel,
  output logic [1:0]     fwd_b_sel,
  output logic           intr_ack,
  output logic           pc_push,
  output logic           flag_save,
  output logic           vec_load,
  output logic           flag_restore,
  output logic           intr_active,
  output logic [2:0]     state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DRAIN  = 3'd1,
    S_PUSH   = 3'd2,
    S_VECTOR = 3'd3,
    S_ISR    = 3'd4
  } state_t;

  localparam logic [2:0] DRAIN_LD = 3'(DRAIN);
  localparam logic       WB_EN    = (FWD_WB != 0);

  state_t     state;
  logic       pending;
  logic [2:0] count;

  // ---------------- hazard detection (combinational) ----------------
  logic use_a, use_b;
  logic ex_hit_a, ex_hit_b, mem_hit_a, mem_hit_b, wb_hit_a, wb_hit_b;
  logic load_use, branch, hazard_stall, rti_fire, irq_take;

  // Branch status is qualified by ex_valid so an empty EX slot never flushes.
  assign branch = ex_valid & ex_branch_taken;
  assign use_a  = id_valid & id_use_a;
  assign use_b  = id_valid & id_use_b;

  // A load in EX has no data yet, so it is never a forwarding source.
  assign ex_hit_a  = ex_reg_write & ~ex_mem_read & (ex_rd == id_rs_a);
  assign ex_hit_b  = ex_reg_write & ~ex_mem_read & (ex_rd == id_rs_b);
  assign mem_hit_a = mem_reg_write & (mem_rd == id_rs_a);
  assign mem_hit_b = mem_reg_write & (mem_rd == id_rs_b);
  assign wb_hit_a  = WB_EN & wb_reg_write & (wb_rd == id_rs_a);
  assign wb_hit_b  = WB_EN & wb_reg_write & (wb_rd == id_rs_b);

  function automatic logic [1:0] pick(input logic used, input logic ex_h,
                                      input logic mem_h, input logic wb_h);
    logic [1:0] sel;
    sel = 2'd0;
    if (used) begin
      if (ex_h)       sel = 2'd1;
      else if (mem_h) sel = 2'd2;
      else if (wb_h)  sel = 2'd3;
    end
    return sel;
  endfunction

  assign fwd_a_sel = pick(use_a, ex_hit_a, mem_hit_a, wb_hit_a);
  assign fwd_b_sel = pick(use_b, ex_hit_b, mem_hit_b, wb_hit_b);

  assign load_use = id_valid & ex_mem_read & ex_reg_write &
                    ((id_use_a & (ex_rd == id_rs_a)) |
                     (id_use_b & (ex_rd == id_rs_b)));

  // A taken branch squashes the decode instruction, so stalling it is moot.
  assign hazard_stall = load_use & ~branch;

  // Fetch stays frozen while draining and pushing, even under a branch:
  // the drain counter restarts instead so the redirected path also empties.
  assign stall_f  = hazard_stall | (state == S_DRAIN) | (state == S_PUSH);
  assign stall_d  = hazard_stall;
  assign flush_d  = branch | (state == S_DRAIN) | (state == S_VECTOR);
  assign flush_ex = branch | load_use;

  assign rti_fire  = id_valid & id_is_rti & ~stall_d;
  // A request seen in IDLE starts draining on the very next edge.
  assign irq_take  = pending | (intr_req & ~intr_active);
  assign state_dbg = state;

  // ---------------- interrupt entry FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      pending      <= 1'b0;
      count        <= 3'd0;
      intr_active  <= 1'b0;
      pc_push      <= 1'b0;
      flag_save    <= 1'b0;
      flush_m      <= 1'b0;
      vec_load     <= 1'b0;
      intr_ack     <= 1'b0;
      flag_restore <= 1'b0;
    end else begin
      pc_push      <= 1'b0;
      flag_save    <= 1'b0;
      flush_m      <= 1'b0;
      vec_load     <= 1'b0;
      intr_ack     <= 1'b0;
      flag_restore <= 1'b0;
      case (state)
        S_IDLE: begin
          if (intr_req && !intr_active) pending <= 1'b1;
          if (irq_take) begin
            state <= S_DRAIN;
            count <= DRAIN_LD;
          end
        end
        S_DRAIN: begin
          if (branch) begin
            count <= DRAIN_LD;
          end else if (count == 3'd1) begin
            state     <= S_PUSH;
            count     <= 3'd0;
            pc_push   <= 1'b1;
            flag_save <= 1'b1;
            flush_m   <= 1'b1;
          end else begin
            count <= count - 3'd1;
          end
        end
        S_PUSH: begin
          state    <= S_VECTOR;
          pending  <= 1'b0;
          vec_load <= 1'b1;
          intr_ack <= 1'b1;
        end
        S_VECTOR: begin
          state       <= S_ISR;
          intr_active <= 1'b1;
        end
        S_ISR: begin
          if (rti_fire) begin
            state        <= S_IDLE;
            intr_active  <= 1'b0;
            flag_restore <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
